fwd_rr_arb: RTL and testbench

Round-robin arbiter sharing one packet forwarder among N packetfilter cores. Cores holding an accepted packet raise `rdy_for_fwd`. The arbiter grants one core per packet, routes the forwarder's reads to that core's buffer, and returns the read data with the core's read latency. It releases the core when the forwarder signals `done`. It is the read-side counterpart of the snooper arbitration.

---
 rtl/fwd_rr_arb_pkg.sv | 23 ++
 rtl/fwd_rr_arb_rr_pick.sv | 35 +++
 rtl/fwd_rr_arb.sv | 173 +++++++++++++++++
 tb/tb_fwd_rr_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_rr_arb_pkg.sv
// Shared definitions for the forwarder round-robin arbiter: FSM encoding,
// clog2 helper and the parameter sanity check used at elaboration.
package fwd_rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Tag must index every core and be at least one bit wide; N limited to 1..32.
  function automatic bit tag_sz_ok(input int unsigned n, input int unsigned tag_sz);
    return (n >= 1) && (n <= 32) && (tag_sz >= 1) && (tag_sz >= clog2(n));
  endfunction

endpackage

// File: rtl/fwd_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1 with wrap modulo N. Shared with the other arbiters.
module rr_pick #(
  parameter int unsigned N      = 4,
  parameter int unsigned TAG_SZ = 5
) (
  input  logic [N-1:0]      req,
  input  logic [TAG_SZ-1:0] last,
  output logic [TAG_SZ-1:0] idx,
  output logic              any
);

  logic [N-1:0] rot;
  int unsigned  base;
  int unsigned  k;

  // Rotate so the search always starts at bit 0, then map back to a core index.
  always_comb begin
    base = 32'(last) + 32'd1;
    if (base >= N) base = 0;
    rot = N'({req, req} >> base);
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        k   = base + j;
        if (k >= N) k = k - N;
        idx = TAG_SZ'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_rr_arb.sv
// Round-robin arbiter sharing one packet forwarder among N filter cores.
// Optional FWD_ARB_REG_OUT_EN registers fwd_addr/fwd_rd_en and rd_data/rd_vld.
module fwd_rr_arb
  import fwd_rr_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PLEN_WIDTH = 12,
  parameter int unsigned N          = 4,
  parameter int unsigned TAG_SZ     = 5,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rdy,
  input  logic                    ack,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_vld,
  output logic [PLEN_WIDTH-1:0]   bytes,
  input  logic                    done,
  input  logic [N-1:0]            rdy_for_fwd,
  output logic [N-1:0]            rdy_for_fwd_ack,
  output logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic [N-1:0]            fwd_rd_en,
  input  logic [N*DATA_WIDTH-1:0] fwd_rd_data,
  input  logic [N*PLEN_WIDTH-1:0] fwd_bytes,
  output logic [N-1:0]            fwd_done
);

  if (!tag_sz_ok(N, TAG_SZ) || RD_LAT < 1) begin : g_param_err
    $error("fwd_rr_arb: invalid N/TAG_SZ/RD_LAT combination");
  end

`ifdef FWD_ARB_REG_OUT_EN
  // One extra stage covers the registered strobe; the output register adds the other.
  localparam int unsigned PIPE = RD_LAT + 1;
`else
  localparam int unsigned PIPE = RD_LAT;
`endif

  arb_state_t state, state_nxt;
  logic [TAG_SZ-1:0] sel, sel_nxt;
  logic [TAG_SZ-1:0] last, last_nxt;
  logic [TAG_SZ-1:0] pick_idx;
  logic              pick_any;
  logic [N-1:0]      sel_oh;
  logic [N-1:0]      rd_en_gated;
  logic              issue;

  logic              pipe_vld [PIPE];
  logic [TAG_SZ-1:0] pipe_tag [PIPE];
  logic              tail_vld;
  logic [TAG_SZ-1:0] tail_tag;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [PLEN_WIDTH-1:0] sel_bytes;

  rr_pick #(
    .N      (N),
    .TAG_SZ (TAG_SZ)
  ) u_pick (
    .req  (rdy_for_fwd),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      last  <= TAG_SZ'(N - 1);
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
    end
  end

  assign sel_oh = N'(1) << sel;

  always_comb begin
    state_nxt       = state;
    sel_nxt         = sel;
    last_nxt        = last;
    rdy_for_fwd_ack = '0;
    fwd_done        = '0;
    rd_en_gated     = '0;
    issue           = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          sel_nxt   = pick_idx;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          rdy_for_fwd_ack = sel_oh;
          state_nxt       = BUSY;
        end
      end
      BUSY: begin
        issue       = rd_en;
        rd_en_gated = rd_en ? sel_oh : '0;
        if (done) begin
          fwd_done  = sel_oh;
          last_nxt  = sel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdy = (state == OFFER);

  // Tags outlive the grant so reads issued alongside done still return correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= sel;
      for (int unsigned i = 1; i < PIPE; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign tail_vld = pipe_vld[PIPE-1];
  assign tail_tag = pipe_tag[PIPE-1];

  always_comb begin
    tail_data = '0;
    sel_bytes = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (tail_tag == TAG_SZ'(i)) tail_data = fwd_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (sel == TAG_SZ'(i))      sel_bytes = fwd_bytes[i*PLEN_WIDTH +: PLEN_WIDTH];
    end
  end

  assign mux_data = tail_vld ? tail_data : '0;
  assign bytes    = (state == BUSY) ? sel_bytes : '0;

`ifdef FWD_ARB_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_addr  <= '0;
      fwd_rd_en <= '0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
    end else begin
      fwd_addr  <= addr;
      fwd_rd_en <= rd_en_gated;
      rd_data   <= mux_data;
      rd_vld    <= tail_vld;
    end
  end
`else
  assign fwd_addr  = addr;
  assign fwd_rd_en = rd_en_gated;
  assign rd_data   = mux_data;
  assign rd_vld    = tail_vld;
`endif

endmodule

// File: tb/tb_fwd_rr_arb.sv
// Self-checking bench for fwd_rr_arb: cycle model of the arbitration rules,
// behavioural core buffers, and directed scenarios with literal expectations.
module tb_fwd_rr_arb;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 12;
  localparam int unsigned N  = 4;
  localparam int unsigned TS = 5;
  localparam int unsigned RL = 2;
`ifdef FWD_ARB_REG_OUT_EN
  localparam int LAT = RL + 2;
  localparam bit REG = 1'b1;
`else
  localparam int LAT = RL;
  localparam bit REG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            ack;
  logic [AW-1:0]   addr;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            rd_vld;
  logic [PW-1:0]   bytes;
  logic            done;
  logic [N-1:0]    rdy_for_fwd;
  logic [N-1:0]    rdy_for_fwd_ack;
  logic [AW-1:0]   fwd_addr;
  logic [N-1:0]    fwd_rd_en;
  logic [N*DW-1:0] fwd_rd_data;
  logic [N*PW-1:0] fwd_bytes;
  logic [N-1:0]    fwd_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  fwd_rr_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PLEN_WIDTH (PW),
    .N          (N),
    .TAG_SZ     (TS),
    .RD_LAT     (RL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .ack             (ack),
    .addr            (addr),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_vld          (rd_vld),
    .bytes           (bytes),
    .done            (done),
    .rdy_for_fwd     (rdy_for_fwd),
    .rdy_for_fwd_ack (rdy_for_fwd_ack),
    .fwd_addr        (fwd_addr),
    .fwd_rd_en       (fwd_rd_en),
    .fwd_rd_data     (fwd_rd_data),
    .fwd_bytes       (fwd_bytes),
    .fwd_done        (fwd_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] core_word(input int i, input int a);
    return {4'hA, 4'(i), 40'h0, 16'(a)};
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic int rr_next(input int lst, input logic [N-1:0] req);
    logic [N-1:0] r;
    for (int k = 1; k <= N; k++) begin
      r = req >> ((lst + k) % N);
      if (r[0]) return (lst + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural core buffers: addressed word after RL cycles, junk otherwise.
  logic [63:0] cpipe [N][RL];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      cpipe[i][0] <= fwd_rd_en[i] ? core_word(i, int'(fwd_addr)) : {$urandom, $urandom};
      for (int s = 1; s < RL; s++) cpipe[i][s] <= cpipe[i][s-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_core
    assign fwd_rd_data[g*DW +: DW] = cpipe[g][RL-1];
    assign fwd_bytes[g*PW +: PW]   = PW'(100 + 10 * g);
  end

  // Reference model: mode 0 idle, 1 offering, 2 serving; reads tracked as a due-time queue.
  typedef struct { int due; int core; int a; } rd_t;
  rd_t q[$];
  int m_mode = 0;
  int m_cur  = 0;
  int m_last = N - 1;
  logic [N-1:0]  m_reg_en   = '0;
  logic [AW-1:0] m_reg_addr = '0;
  logic [N-1:0]  e_en_now, e_en, e_ack, e_done;
  logic [AW-1:0] e_addr;
  logic          e_rdy, e_vld;
  logic [63:0]   e_data;
  logic [PW-1:0] e_bytes;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_rdy",  64'(rdy), 64'(0));
        chk("rst_vld",  64'(rd_vld), 64'(0));
        chk("rst_data", rd_data, 64'(0));
        chk("rst_ack",  64'(rdy_for_fwd_ack), 64'(0));
        chk("rst_en",   64'(fwd_rd_en), 64'(0));
        chk("rst_done", 64'(fwd_done), 64'(0));
        chk("rst_bytes", 64'(bytes), 64'(0));
        chk("rst_addr", 64'(fwd_addr), REG ? 64'(0) : 64'(addr));
        m_mode = 0; m_cur = 0; m_last = N - 1;
        q.delete();
        m_reg_en = '0; m_reg_addr = '0;
      end else begin
        e_rdy    = (m_mode == 1);
        e_ack    = (m_mode == 1 && ack) ? onehot(m_cur) : '0;
        e_en_now = (m_mode == 2 && rd_en) ? onehot(m_cur) : '0;
        e_done   = (m_mode == 2 && done) ? onehot(m_cur) : '0;
        e_bytes  = (m_mode == 2) ? PW'(100 + 10 * m_cur) : '0;
        e_vld = 1'b0; e_data = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e_vld  = 1'b1;
          e_data = core_word(q[0].core, q[0].a);
          void'(q.pop_front());
        end
        e_en   = REG ? m_reg_en : e_en_now;
        e_addr = REG ? m_reg_addr : addr;
        chk("m_rdy",   64'(rdy), 64'(e_rdy));
        chk("m_ack",   64'(rdy_for_fwd_ack), 64'(e_ack));
        chk("m_en",    64'(fwd_rd_en), 64'(e_en));
        chk("m_addr",  64'(fwd_addr), 64'(e_addr));
        chk("m_done",  64'(fwd_done), 64'(e_done));
        chk("m_bytes", 64'(bytes), 64'(e_bytes));
        chk("m_vld",   64'(rd_vld), 64'(e_vld));
        chk("m_data",  rd_data, e_data);
        if (m_mode == 2 && rd_en) q.push_back('{cyc + LAT, m_cur, int'(addr)});
        m_reg_en   = e_en_now;
        m_reg_addr = addr;
        case (m_mode)
          0: if (|rdy_for_fwd) begin m_cur = rr_next(m_last, rdy_for_fwd); m_mode = 1; end
          1: if (ack) m_mode = 2;
          2: if (done) begin m_last = m_cur; m_mode = 0; end
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; ack = 1'b0; rd_en = 1'b0; done = 1'b0; addr = '0; rdy_for_fwd = '0;
    tick();
    #1;
    chk("lit_rst_rdy", 64'(rdy), 64'(0));
    chk("lit_rst_vld", 64'(rd_vld), 64'(0));
    tick();
    rst = 1'b0;
  endtask

  task automatic serve(output int core, input int reads, input int a0);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rdy_wait", 64'(rdy), 64'(1));
    ack = 1'b1;
    #1;
    core = -1;
    for (int i = 0; i < N; i++) if (rdy_for_fwd_ack == onehot(i)) core = i;
    tick();
    ack = 1'b0;
    for (int r = 0; r < reads; r++) begin
      rd_en = 1'b1; addr = AW'(a0 + r);
      tick();
      rd_en = 1'b0; addr = '0;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  int got;
  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b1; ack = 1'b0; rd_en = 1'b0; done = 1'b0; addr = '0; rdy_for_fwd = '0;
    reset_dut();

    // Single request from core 2, one read at address 5.
    rdy_for_fwd = 4'b0100;
    tick();
    chk("s1_rdy", 64'(rdy), 64'(1));
    ack = 1'b1;
    #1 chk("s1_ack", 64'(rdy_for_fwd_ack), 64'(4'b0100));
    tick();
    ack = 1'b0; rdy_for_fwd = '0;
    rd_en = 1'b1; addr = 9'd5;
    #1;
    chk("s1_en", 64'(fwd_rd_en), REG ? 64'(0) : 64'(4'b0100));
    chk("s1_bytes", 64'(bytes), 64'(120));
    tick();
    rd_en = 1'b0; addr = '0;
    #1 chk("s1_en_q", 64'(fwd_rd_en), REG ? 64'(4'b0100) : 64'(0));
    repeat (LAT - 1) tick();
    #1;
    chk("s1_vld", 64'(rd_vld), 64'(1));
    chk("s1_data", rd_data, 64'hA200_0000_0000_0005);
    done = 1'b1;
    #1 chk("s1_done", 64'(fwd_done), 64'(4'b0100));
    tick();
    done = 1'b0;
    chk("s1_idle", 64'(rdy), 64'(0));
    tick();
    chk("s1_idle2", 64'(rdy), 64'(0));

    // All cores requesting: strict rotation starting at core 0.
    reset_dut();
    rdy_for_fwd = '1;
    for (int p = 0; p < 8; p++) begin
      serve(got, 1, 16 + p);
      chk("s2_grant", 64'(got), 64'(order[p]));
    end
    rdy_for_fwd = '0;
    repeat (LAT + 1) tick();

    // Offer stays on core 1 while core 0 joins; then 2 is served before 0.
    reset_dut();
    rdy_for_fwd = 4'b0010;
    tick();
    rdy_for_fwd = 4'b0011;
    tick();
    ack = 1'b1;
    #1 chk("s3_ack1", 64'(rdy_for_fwd_ack), 64'(4'b0010));
    tick();
    ack = 1'b0; rdy_for_fwd = 4'b0101;
    done = 1'b1;
    tick();
    done = 1'b0;
    serve(got, 2, 32);
    chk("s3_grant2", 64'(got), 64'(2));
    rdy_for_fwd = 4'b0001;
    serve(got, 1, 40);
    chk("s3_grant0", 64'(got), 64'(0));
    rdy_for_fwd = '0;
    repeat (LAT + 1) tick();

    // Read on the same cycle as done still returns from the released core.
    reset_dut();
    rdy_for_fwd = 4'b1000;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0; rdy_for_fwd = '0;
    rd_en = 1'b1; done = 1'b1; addr = 9'd9;
    #1 chk("s4_done", 64'(fwd_done), 64'(4'b1000));
    tick();
    rd_en = 1'b0; done = 1'b0; addr = '0;
    repeat (LAT - 1) tick();
    #1;
    chk("s4_vld", 64'(rd_vld), 64'(1));
    chk("s4_data", rd_data, 64'hA300_0000_0000_0009);
    chk("s4_rdy", 64'(rdy), 64'(0));

    // ack in IDLE and done in OFFER have no effect.
    reset_dut();
    ack = 1'b1;
    #1 chk("s5_ack_idle", 64'(rdy_for_fwd_ack), 64'(0));
    tick();
    ack = 1'b0;
    chk("s5_still_idle", 64'(rdy), 64'(0));
    rdy_for_fwd = 4'b0001;
    tick();
    done = 1'b1;
    #1 chk("s5_done_offer", 64'(fwd_done), 64'(0));
    tick();
    done = 1'b0;
    chk("s5_still_offer", 64'(rdy), 64'(1));
    serve(got, 0, 0);
    chk("s5_grant", 64'(got), 64'(0));
    rdy_for_fwd = '0;

    // Reset while serving core 1 with two reads outstanding.
    rdy_for_fwd = 4'b0010;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0; rdy_for_fwd = '0;
    rd_en = 1'b1; addr = 9'd1;
    tick();
    addr = 9'd2;
    tick();
    rd_en = 1'b0; addr = '0;
    rst = 1'b1;
    #1;
    chk("s6_vld", 64'(rd_vld), 64'(0));
    chk("s6_rdy", 64'(rdy), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("s6_idle", 64'(rdy), 64'(0));
    chk("s6_vld2", 64'(rd_vld), 64'(0));
    repeat (LAT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
